// File: rtl/mm_pkg.sv
// mm_pkg: constants, mode/state enums and per-mode saturation bounds shared
// by mm_ctrl, mm_requant and requant_sat.
package mm_pkg;

  localparam int ACC_W = 24;
  localparam int OUT_W = 8;
  localparam int DEPTH = 1024;

  // Cycles spent in DRAIN so the last element clears the two datapath stages
  // plus the read-data stage before DONE is signalled.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  typedef enum logic [1:0] {
    MODE_INT8     = 2'd0,
    MODE_INT4     = 2'd1,
    MODE_INT4_VSQ = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic signed [7:0] SAT8_HI = 8'sh7F;
  localparam logic signed [7:0] SAT8_LO = 8'sh80;
  localparam logic signed [7:0] SAT4_HI = 8'sh07;
  localparam logic signed [7:0] SAT4_LO = 8'shF8;

  // Upper clamp for a mode; both INT4 flavours share the 4-bit range.
  function automatic logic signed [7:0] sat_hi(input mode_e m);
    return (m == MODE_INT8) ? SAT8_HI : SAT4_HI;
  endfunction

  // Lower clamp for a mode.
  function automatic logic signed [7:0] sat_lo(input mode_e m);
    return (m == MODE_INT8) ? SAT8_LO : SAT4_LO;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// requant_sat: two-stage registered requantisation datapath.
//   stage 1: signed accumulator x unsigned scale
//   stage 2: round-half-up right shift, optional ReLU, clamp to mode range
// Optional feature macro: MM_REQUANT_RELU_EN (fused ReLU before the clamp).
module requant_sat #(
  parameter int ACC_W   = 24,
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [ACC_W-1:0]   in_acc,
  input  logic [1:0]         mode,
  input  logic [SCALE_W-1:0] scale,
  input  logic [SHIFT_W-1:0] shift,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [OUT_W-1:0]   out_data
);
  import mm_pkg::*;

  // Product width: signed accumulator times zero-extended unsigned scale.
  localparam int P_W = ACC_W + SCALE_W + 1;

  logic signed [P_W-1:0] prod_next;
  logic signed [P_W-1:0] prod_reg;
  logic                  p1_valid_reg;
  logic [ADDR_W-1:0]     p1_addr_reg;

  logic [P_W-1:0]        bias;
  logic signed [P_W-1:0] sum;
  logic signed [P_W-1:0] r;
  logic signed [P_W-1:0] r_relu;
  logic signed [P_W-1:0] hi_ext;
  logic signed [P_W-1:0] lo_ext;
  logic signed [7:0]     hi;
  logic signed [7:0]     lo;
  logic [OUT_W-1:0]      sat_next;

  logic                  out_valid_reg;
  logic [ADDR_W-1:0]     out_addr_reg;
  logic [OUT_W-1:0]      out_data_reg;

  // Stage 1 combinational multiply; both operands widened as signed first.
  always_comb begin
    prod_next = P_W'($signed(in_acc)) * P_W'($signed({1'b0, scale}));
  end

  // Stage 1 register: product, element address and valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_reg     <= '0;
      p1_valid_reg <= 1'b0;
      p1_addr_reg  <= '0;
    end else begin
      prod_reg     <= prod_next;
      p1_valid_reg <= in_valid;
      p1_addr_reg  <= in_addr;
    end
  end

  // Stage 2 combinational round, shift, optional ReLU and clamp.
  always_comb begin
    hi     = sat_hi(mode_e'(mode));
    lo     = sat_lo(mode_e'(mode));
    hi_ext = P_W'(hi);
    lo_ext = P_W'(lo);
    // Half-LSB bias makes the arithmetic shift round half toward +inf.
    bias   = (shift == '0) ? '0 : (P_W'(1) << (shift - SHIFT_W'(1)));
    sum    = prod_reg + $signed(bias);
    r      = sum >>> shift;
`ifdef MM_REQUANT_RELU_EN
    r_relu = r[P_W-1] ? '0 : r;
`else
    r_relu = r;
`endif
    if (r_relu > hi_ext) begin
      sat_next = OUT_W'(hi);
    end else if (r_relu < lo_ext) begin
      sat_next = OUT_W'(lo);
    end else begin
      sat_next = r_relu[OUT_W-1:0];
    end
  end

  // Stage 2 register: quantised word, address and valid drive the RAM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= p1_valid_reg;
      out_addr_reg  <= p1_addr_reg;
      out_data_reg  <= sat_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;
  assign out_data  = out_data_reg;

endmodule

// File: rtl/mm_requant.sv
// mm_requant: writeback stage after the matrix multiply. Streams the
// accumulator bank through requant_sat and writes the quantised results.
// Optional feature macro: MM_REQUANT_RELU_EN (handled inside requant_sat).
module mm_requant #(
  parameter int ACC_W   = mm_pkg::ACC_W,
  parameter int OUT_W   = mm_pkg::OUT_W,
  parameter int DEPTH   = mm_pkg::DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [1:0]         i_mode,
  input  logic [SCALE_W-1:0] i_scale,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic               o_acc_ren,
  output logic [ADDR_W-1:0]  o_acc_addr,
  input  logic [ACC_W-1:0]   i_acc_rdata,
  output logic               o_out_we,
  output logic [ADDR_W-1:0]  o_out_addr,
  output logic [OUT_W-1:0]   o_out_wdata,
  output logic               o_busy,
  output logic               o_done
);
  import mm_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e               state_reg;
  state_e               state_next;
  logic [ADDR_W-1:0]    addr_reg;
  logic [ADDR_W-1:0]    addr_next;
  logic [1:0]           drain_reg;
  logic [1:0]           drain_next;
  logic                 load;

  mode_e                mode_reg;
  logic [SCALE_W-1:0]   scale_reg;
  logic [SHIFT_W-1:0]   shift_reg;

  logic                 rd_valid_reg;
  logic [ADDR_W-1:0]    rd_addr_reg;

  // Control state register: FSM, address counter and drain counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      drain_reg <= drain_next;
    end
  end

  // Next-state logic; mode 3 and starts while busy are simply not accepted.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    drain_next = drain_reg;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_start && (i_mode != MODE_RSVD)) begin
          state_next = ST_RUN;
          addr_next  = '0;
          load       = 1'b1;
        end
      end
      ST_RUN: begin
        if (addr_reg == LAST_ADDR) begin
          state_next = ST_DRAIN;
          drain_next = '0;
        end else begin
          addr_next = addr_reg + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          state_next = ST_DONE;
        end else begin
          drain_next = drain_reg + 2'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        addr_next  = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    o_acc_ren  = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_acc_addr = addr_reg;
    if (state_reg == ST_RUN)  o_acc_ren = 1'b1;
    if (state_reg != ST_IDLE) o_busy    = 1'b1;
    if (state_reg == ST_DONE) o_done    = 1'b1;
  end

  // Operation parameters are captured once so the inputs may change mid-run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_reg  <= MODE_INT8;
      scale_reg <= '0;
      shift_reg <= '0;
    end else if (load) begin
      mode_reg  <= mode_e'(i_mode);
      scale_reg <= i_scale;
      shift_reg <= i_shift;
    end
  end

  // Tag returning read data with its address; RAM data lands one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
    end else begin
      rd_valid_reg <= o_acc_ren;
      rd_addr_reg  <= addr_reg;
    end
  end

  requant_sat #(
    .ACC_W   (ACC_W),
    .SCALE_W (SCALE_W),
    .SHIFT_W (SHIFT_W),
    .OUT_W   (OUT_W),
    .ADDR_W  (ADDR_W)
  ) u_requant_sat (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .in_valid  (rd_valid_reg),
    .in_addr   (rd_addr_reg),
    .in_acc    (i_acc_rdata),
    .mode      (mode_reg),
    .scale     (scale_reg),
    .shift     (shift_reg),
    .out_valid (o_out_we),
    .out_addr  (o_out_addr),
    .out_data  (o_out_wdata)
  );

endmodule
